// File: rtl/alu.sv
// Registered WIDTH-bit ALU: ADD, SUB, AND, OR selected by a 2-bit opcode.
// Result, carry/borrow and zero flag are captured together on the rising clock edge.
module alu #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] f,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_t;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] f_next;
    logic             carry_next;

    // The extra top bit of the widened subtraction is the borrow: it is set exactly when a < b.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        // NOTE: defaults ahead of the case keep every path assigned, so no latch is inferred.
        f_next     = '0;
        carry_next = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                f_next     = sum_ext[WIDTH-1:0];
                carry_next = sum_ext[WIDTH];
            end
            OP_SUB: begin
                f_next     = diff_ext[WIDTH-1:0];
                carry_next = diff_ext[WIDTH];
            end
            OP_AND:  f_next = a & b;
            OP_OR:   f_next = a | b;
            default: f_next = '0;
        endcase
    end

    // zero comes from f_next so the flag is registered in step with f.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments here so every register samples pre-edge values.
        if (rst) begin
            f     <= '0;
            carry <= 1'b0;
            zero  <= 1'b1;
        end else begin
            f     <= f_next;
            carry <= carry_next;
            zero  <= (f_next == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: expected results are queued when stimulus is driven
// and popped for comparison one rising edge later.
module tb_alu;

    localparam int WIDTH = 5;

    typedef struct packed {
        logic [WIDTH-1:0] f;
        logic             carry;
        logic             zero;
    } res_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic [WIDTH-1:0] f;
    logic             carry;
    logic             zero;

    res_t exp_q[$];
    int   n_cmp;
    int   n_err;

    alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .op    (op),
        .f     (f),
        .carry (carry),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written with plain integer arithmetic and the mod-32 rules.
    function automatic res_t model(input int ia, input int ib, input int iop);
        res_t r;
        int   full;
        int   fv;
        int   cv;
        fv = 0;
        cv = 0;
        case (iop)
            0: begin
                full = ia + ib;
                fv   = full % 32;
                cv   = (full >= 32) ? 1 : 0;
            end
            1: begin
                fv = (ia - ib + 32) % 32;
                cv = (ia < ib) ? 1 : 0;
            end
            2: fv = ia & ib;
            default: fv = ia | ib;
        endcase
        r.f     = fv[WIDTH-1:0];
        r.carry = cv[0];
        r.zero  = (fv == 0);
        return r;
    endfunction

    // Drives one operation at the falling edge and records its expected result.
    task automatic issue(input int ia, input int ib, input int iop);
        @(negedge clk);
        a  = ia[WIDTH-1:0];
        b  = ib[WIDTH-1:0];
        op = iop[1:0];
        exp_q.push_back(model(ia, ib, iop));
    endtask

    task automatic test_reset();
        res_t rv;
        rv = '{f: '0, carry: 1'b0, zero: 1'b1};
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({f, carry, zero} !== rv) begin
            n_err++;
            $display("FAIL reset_initial: got f=%0d carry=%0b zero=%0b, want f=0 carry=0 zero=1", f, carry, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        a = 5'd6; b = 5'd12; op = 2'b00;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({f, carry, zero} !== model(6, 12, 0)) begin
            n_err++;
            $display("FAIL reset_preload: got f=%0d carry=%0b zero=%0b, want f=18 carry=0 zero=0", f, carry, zero);
        end
        // Assert reset between edges; outputs must clear without any clock edge.
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({f, carry, zero} !== rv) begin
            n_err++;
            $display("FAIL reset_async: got f=%0d carry=%0b zero=%0b, want f=0 carry=0 zero=1", f, carry, zero);
        end
        a = 5'd31; b = 5'd31; op = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({f, carry, zero} !== rv) begin
            n_err++;
            $display("FAIL reset_hold: got f=%0d carry=%0b zero=%0b, want f=0 carry=0 zero=1", f, carry, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({f, carry, zero} !== rv) begin
            n_err++;
            $display("FAIL reset_release_before_edge: got f=%0d carry=%0b zero=%0b, want f=0 carry=0 zero=1", f, carry, zero);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({f, carry, zero} !== model(31, 31, 0)) begin
            n_err++;
            $display("FAIL reset_first_edge: got f=%0d carry=%0b zero=%0b, want f=30 carry=1 zero=0", f, carry, zero);
        end
    endtask

    // Runs a table of directed vectors for one feature, checking each one edge after issue.
    task automatic run_vectors(input string name, input int va[], input int vb[], input int vop[]);
        res_t e;
        for (int i = 0; i < va.size(); i++) begin
            issue(va[i], vb[i], vop[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if ({f, carry, zero} !== e) begin
                n_err++;
                $display("FAIL %s[%0d] a=%0d b=%0d: got f=%0d carry=%0b zero=%0b, want f=%0d carry=%0b zero=%0b",
                         name, i, va[i], vb[i], f, carry, zero, e.f, e.carry, e.zero);
            end
        end
    endtask

    task automatic test_add();
        // 31+1 is the wrap boundary.
        run_vectors("add", '{6, 20, 31, 0}, '{12, 15, 1, 0}, '{0, 0, 0, 0});
    endtask

    task automatic test_sub();
        run_vectors("sub", '{2, 9, 0, 31, 16}, '{15, 9, 1, 0, 17}, '{1, 1, 1, 1, 1});
    endtask

    task automatic test_and();
        run_vectors("and", '{12, 21, 31}, '{14, 10, 19}, '{2, 2, 2});
    endtask

    task automatic test_or();
        run_vectors("or", '{12, 0, 17}, '{4, 0, 10}, '{3, 3, 3});
    endtask

    // New operation every cycle; garbage on the inputs mid-cycle must not reach the outputs.
    task automatic test_back_to_back();
        res_t e;
        int   va[8]  = '{7, 30, 5, 18, 25, 3, 9, 0};
        int   vb[8]  = '{9, 31, 21, 3, 7, 11, 24, 0};
        int   vop[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < 8; i++) begin
            issue(va[i], vb[i], vop[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if ({f, carry, zero} !== e) begin
                n_err++;
                $display("FAIL b2b[%0d] op=%0d a=%0d b=%0d: got f=%0d carry=%0b zero=%0b, want f=%0d carry=%0b zero=%0b",
                         i, vop[i], va[i], vb[i], f, carry, zero, e.f, e.carry, e.zero);
            end
            a = 5'($urandom_range(0, 31));
            b = 5'($urandom_range(0, 31));
            op = 2'($urandom_range(0, 3));
            #2;
            n_cmp++;
            if ({f, carry, zero} !== e) begin
                n_err++;
                $display("FAIL b2b_midcycle[%0d]: got f=%0d carry=%0b zero=%0b, want f=%0d carry=%0b zero=%0b",
                         i, f, carry, zero, e.f, e.carry, e.zero);
            end
        end
    endtask

    task automatic test_random();
        res_t e;
        int   ra;
        int   rb;
        int   rop;
        for (int i = 0; i < 200; i++) begin
            ra  = $urandom_range(0, 31);
            rb  = $urandom_range(0, 31);
            rop = $urandom_range(0, 3);
            issue(ra, rb, rop);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if ({f, carry, zero} !== e) begin
                n_err++;
                $display("FAIL random[%0d] op=%0d a=%0d b=%0d: got f=%0d carry=%0b zero=%0b, want f=%0d carry=%0b zero=%0b",
                         i, rop, ra, rb, f, carry, zero, e.f, e.carry, e.zero);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        a     = '0;
        b     = '0;
        op    = '0;
        test_reset();
        test_add();
        test_sub();
        test_and();
        test_or();
        test_back_to_back();
        test_random();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
